// File: rtl/cam_feat_pkg.sv
// Shared camera feature-map constants and types.
// The assembler and the downstream pooling stage both import this package.
package cam_feat_pkg;

    localparam int unsigned BIT_WIDTH  = 8;
    localparam int unsigned CHANNELS   = 32;
    localparam int unsigned PIXEL_BITS = CHANNELS * BIT_WIDTH;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } asm_state_e;

endpackage

// File: rtl/activation_map_assembler.sv
// Collects one HxW raster frame of 32-channel INT8 pixels into a flat buffer.
// The buffer is presented to the pooling stage; short and long frames are flagged.
module activation_map_assembler
    import cam_feat_pkg::*;
#(
    parameter int unsigned H     = 4,
    parameter int unsigned W     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [PIXEL_BITS-1:0]     pix_data,
    input  logic                      pix_last,
    output logic                      map_valid,
    input  logic                      map_ready,
    output logic [H*W*PIXEL_BITS-1:0] activation_map_flat,
    output logic                      frame_err,
    output logic [CNT_W-1:0]          frame_cnt
);

    localparam int unsigned NPIX   = H * W;
    localparam int unsigned IDX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned FLAT_W = NPIX * PIXEL_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    if (H < 1) begin : g_bad_h
        $fatal(1, "activation_map_assembler: H must be >= 1");
    end
    if (W < 1) begin : g_bad_w
        $fatal(1, "activation_map_assembler: W must be >= 1");
    end

    asm_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FLAT_W-1:0] buf_q, buf_d;
    logic              map_valid_q, map_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              fill_wr;

    // Ready is a pure state decode so map_ready never reaches it combinationally.
    assign pix_ready           = rst_n && (state_q != HOLD);
    assign map_valid           = map_valid_q;
    assign frame_err           = frame_err_q;
    assign frame_cnt           = frame_cnt_q;
    assign activation_map_flat = buf_q;

    assign fill_wr = pix_valid && (state_q == FILL);

    // Per-slot write enable decoded from the current pixel index.
    always_comb begin
        buf_d = buf_q;
        for (int unsigned p = 0; p < NPIX; p++) begin
            if (fill_wr && (idx_q == IDX_W'(p))) begin
                buf_d[p*PIXEL_BITS +: PIXEL_BITS] = pix_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        map_valid_d = map_valid_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            FILL: begin
                if (pix_valid) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (pix_last) begin
                            state_d     = HOLD;
                            map_valid_d = 1'b1;
                        end else begin
                            state_d     = DRAIN;
                            frame_err_d = 1'b1;
                        end
                    end else if (pix_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (map_valid_q && map_ready) begin
                    state_d     = FILL;
                    map_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Overlong tail is dropped; the buffer is left alone.
                if (pix_valid && pix_last) begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d     = FILL;
                idx_d       = '0;
                map_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= '0;
            buf_q       <= '0;
            map_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            map_valid_q <= map_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_activation_map_assembler.sv
// Directed bench for activation_map_assembler: a 2x2 instance driven through nominal,
// backpressure, short, long and mid-frame-reset cases, plus a 1x1 instance.
module tb_activation_map_assembler;
    import cam_feat_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          pix_valid, pix_ready, pix_last;
    logic          map_valid, map_ready, frame_err;
    logic [255:0]  pix_data;
    logic [1023:0] flat;
    logic [15:0]   frame_cnt;

    logic          pix_valid1, pix_ready1, pix_last1;
    logic          map_valid1, map_ready1, frame_err1;
    logic [255:0]  pix_data1;
    logic [255:0]  flat1;
    logic [15:0]   frame_cnt1;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int exp_err  = 0;
    logic [1023:0] exp_q[$];

    activation_map_assembler #(.H(2), .W(2), .CNT_W(16)) u_dut0 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pix_valid           (pix_valid),
        .pix_ready           (pix_ready),
        .pix_data            (pix_data),
        .pix_last            (pix_last),
        .map_valid           (map_valid),
        .map_ready           (map_ready),
        .activation_map_flat (flat),
        .frame_err           (frame_err),
        .frame_cnt           (frame_cnt)
    );

    activation_map_assembler #(.H(1), .W(1), .CNT_W(16)) u_dut1 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pix_valid           (pix_valid1),
        .pix_ready           (pix_ready1),
        .pix_data            (pix_data1),
        .pix_last            (pix_last1),
        .map_valid           (map_valid1),
        .map_ready           (map_ready1),
        .activation_map_flat (flat1),
        .frame_err           (frame_err1),
        .frame_cnt           (frame_cnt1)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] mk_frame(input logic [7:0] base);
        logic [1023:0] f;
        logic [7:0]    b;
        for (int p = 0; p < 4; p++) begin
            b = 8'(base + 8'(p));
            f[p*256 +: 256] = {32{b}};
        end
        return f;
    endfunction

    // Scoreboard pops on every map handshake, then advances one clock.
    task automatic cycle();
        logic [1023:0] e;
        if (map_valid && map_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected_map observed=handshake expected=no frame pending");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < 4; p++) begin
                    check($sformatf("sb_pixel%0d", p), flat[p*256 +: 256], e[p*256 +: 256]);
                end
            end
        end
        if (frame_err) err_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] b, input logic last);
        logic r;
        pix_valid = 1'b1;
        pix_data  = {32{b}};
        pix_last  = last;
        for (int n = 0; n < 64; n++) begin
            r = pix_ready;
            cycle();
            if (r) return;
        end
        check("beat_timeout", 256'(0), 256'(1));
    endtask

    task automatic send_good(input logic [7:0] base);
        exp_q.push_back(mk_frame(base));
        for (int p = 0; p < 4; p++) begin
            send_beat(8'(base + 8'(p)), (p == 3));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pix_valid  = 1'b0; pix_data  = '0; pix_last  = 1'b0; map_ready  = 1'b1;
        pix_valid1 = 1'b0; pix_data1 = '0; pix_last1 = 1'b0; map_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_ready", pix_ready, 1'b0);
        check("rst_map_valid", map_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_flat0", flat[255:0], 256'd0);
        check("rst_pix_ready1", pix_ready1, 1'b0);
        rst_n = 1'b1;
        #1;
        check("post_rst_pix_ready", pix_ready, 1'b1);

        // Nominal frame
        exp_q.push_back(mk_frame(8'h10));
        send_beat(8'h10, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h12, 1'b0);
        check("nom_not_early", map_valid, 1'b0);
        send_beat(8'h13, 1'b1);
        check("nom_map_valid", map_valid, 1'b1);
        check("nom_hold_ready", pix_ready, 1'b0);
        pix_valid = 1'b0;
        cycle();
        check("nom_map_drop", map_valid, 1'b0);
        check("nom_frame_cnt", frame_cnt, 16'd1);
        check("nom_ready_back", pix_ready, 1'b1);
        check("nom_no_err", 256'(err_seen), 256'(0));

        // Backpressure with upstream holding a valid beat
        map_ready = 1'b0;
        send_good(8'h20);
        pix_valid = 1'b1; pix_data = {32{8'h30}}; pix_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_pix_ready", pix_ready, 1'b0);
            check("bp_map_valid", map_valid, 1'b1);
            check("bp_flat_p3", flat[1023:768], {32{8'h23}});
            cycle();
        end
        map_ready = 1'b1;
        cycle();
        check("bp_ready_after", pix_ready, 1'b1);
        check("bp_map_drop", map_valid, 1'b0);
        check("bp_frame_cnt", frame_cnt, 16'd2);
        send_good(8'h30);
        pix_valid = 1'b0;
        cycle();
        check("bp_frame_cnt2", frame_cnt, 16'd3);

        // Short frame
        send_beat(8'h40, 1'b0);
        send_beat(8'h41, 1'b1);
        exp_err++;
        check("short_err", frame_err, 1'b1);
        check("short_no_map", map_valid, 1'b0);
        pix_valid = 1'b0;
        cycle();
        check("short_err_1cyc", frame_err, 1'b0);
        check("short_no_map2", map_valid, 1'b0);
        send_good(8'hA0);
        pix_valid = 1'b0;
        cycle();
        check("short_frame_cnt", frame_cnt, 16'd4);

        // Long frame
        send_beat(8'h50, 1'b0);
        send_beat(8'h51, 1'b0);
        send_beat(8'h52, 1'b0);
        send_beat(8'h53, 1'b0);
        exp_err++;
        check("long_err", frame_err, 1'b1);
        check("long_no_map", map_valid, 1'b0);
        send_beat(8'h54, 1'b0);
        check("long_err_1cyc", frame_err, 1'b0);
        check("long_drain_ready", pix_ready, 1'b1);
        send_beat(8'h55, 1'b1);
        check("long_no_map2", map_valid, 1'b0);
        check("long_no_err2", frame_err, 1'b0);
        pix_valid = 1'b0;
        cycle();
        check("long_no_map3", map_valid, 1'b0);
        send_good(8'h60);
        pix_valid = 1'b0;
        cycle();
        check("long_frame_cnt", frame_cnt, 16'd5);

        // Reset in the middle of a frame
        send_beat(8'h70, 1'b0);
        send_beat(8'h71, 1'b0);
        pix_data = {32{8'h72}};
        rst_n = 1'b0;
        #2;
        check("mrst_map_valid", map_valid, 1'b0);
        check("mrst_pix_ready", pix_ready, 1'b0);
        check("mrst_frame_cnt", frame_cnt, 16'd0);
        check("mrst_frame_err", frame_err, 1'b0);
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        send_good(8'h80);
        pix_valid = 1'b0;
        cycle();
        check("mrst_frame_cnt2", frame_cnt, 16'd1);
        cycle();
        check("err_pulses", 256'(err_seen), 256'(exp_err));
        check("sb_drained", 256'(exp_q.size()), 256'(0));

        // 1x1 instance: good single-beat frame, then long frame through DRAIN
        pix_valid1 = 1'b1; pix_data1 = {32{8'h7F}}; pix_last1 = 1'b1;
        @(posedge clk); #1;
        check("one_map_valid", map_valid1, 1'b1);
        check("one_flat", flat1, {32{8'h7F}});
        check("one_hold_ready", pix_ready1, 1'b0);
        pix_valid1 = 1'b0;
        @(posedge clk); #1;
        check("one_map_drop", map_valid1, 1'b0);
        check("one_frame_cnt", frame_cnt1, 16'd1);
        pix_valid1 = 1'b1; pix_data1 = {32{8'h11}}; pix_last1 = 1'b0;
        @(posedge clk); #1;
        check("one_long_err", frame_err1, 1'b1);
        check("one_long_no_map", map_valid1, 1'b0);
        check("one_drain_ready", pix_ready1, 1'b1);
        pix_data1 = {32{8'h12}};
        @(posedge clk); #1;
        check("one_drain_no_err", frame_err1, 1'b0);
        pix_last1 = 1'b1;
        @(posedge clk); #1;
        check("one_drain_exit", map_valid1, 1'b0);
        pix_data1 = {32{8'h33}};
        @(posedge clk); #1;
        check("one_map_valid2", map_valid1, 1'b1);
        check("one_flat2", flat1, {32{8'h33}});
        check("one_err_clear", frame_err1, 1'b0);
        pix_valid1 = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/activation_map_assembler.md
Name: activation_map_assembler

Overview:
- Sits directly upstream of the camera max-pooling stage.
- Accepts the final conv activations as a raster stream of pixel beats. Each beat is 32 channels × INT8, 256 bits.
- Assembles one H×W frame into a flat register buffer and presents it to the pooling stage with a valid/ready handshake.
- Enforces frame length and reports malformed frames.

Parameters:
- H, 4: feature map height, ≥1 (elaboration-time fatal otherwise).
- W, 4: feature map width, ≥1 (elaboration-time fatal otherwise).
- CNT_W, 16: width of the accepted-frame counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- pix_valid, input, 1: upstream beat valid.
- pix_ready, output, 1: beat accepted when pix_valid && pix_ready.
- pix_data, input, 256: one pixel, channel c at bits [c*8 +: 8].
- pix_last, input, 1: marks the final beat of a frame.
- map_valid, output, 1: assembled frame available.
- map_ready, input, 1: pooling stage consumes the frame.
- activation_map_flat, output, H*W*256: pixel p at bits [p*256 +: 256], channel c at [p*256 + c*8 +: 8].
- frame_err, output, 1: one-cycle pulse on a malformed frame.
- frame_cnt, output, CNT_W: count of frames delivered via the map handshake; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=FILL, pixel index idx=0, buffer all zeros, map_valid=0, frame_err=0, frame_cnt=0. pix_ready is forced 0 while rst_n=0.
- pix_ready is a decode of state: 1 in FILL and DRAIN, 0 in HOLD. It has no combinational path from map_ready.
- FILL, on each accepted beat: write pix_data into slot idx, then:
  - idx<H*W-1, pix_last=0: idx++.
  - idx<H*W-1, pix_last=1 (short frame): pulse frame_err next cycle, idx←0, stay FILL. Partial data is never presented; stale slots are overwritten by the next frame.
  - idx==H*W-1, pix_last=1: go to HOLD, map_valid=1 starting the next cycle, idx←0.
  - idx==H*W-1, pix_last=0 (long frame): pulse frame_err next cycle, go to DRAIN. The map is not presented.
- DRAIN: pix_ready=1, beats are discarded with the buffer untouched. A beat with pix_last=1 returns to FILL with idx=0. No additional frame_err pulse.
- HOLD:
  - map_valid=1; activation_map_flat is stable; no beats are accepted.
  - On map_valid && map_ready: frame_cnt++ and go to FILL. map_valid=0 and pix_ready=1 from the next cycle.
- H*W==1: every frame is exactly one beat. A beat without pix_last is a long frame, which leads to DRAIN.
- Latency: map_valid rises 1 cycle after the last-beat handshake.
- Throughput: 1 beat/cycle within a frame. There is one bubble cycle between map consumption and the next accepted beat, which is acceptable.
- activation_map_flat drives the buffer directly. In FILL its contents are undefined for the consumer and must only be sampled while map_valid=1.
- pix_valid while pix_ready=0: the beat is held by upstream and not lost. Upstream is required to keep pix_data stable under valid.
- Reset mid-frame or in HOLD: immediate return to reset values. Any partial or held frame is lost, with no frame_err.
- frame_err is never asserted for consecutive good frames. It asserts for exactly 1 cycle per malformed frame.

Decomposition:
- Shared package cam_feat_pkg:
  - BIT_WIDTH=8, CHANNELS=32, PIXEL_BITS=CHANNELS*BIT_WIDTH.
  - pixel_t (logic [PIXEL_BITS-1:0]).
  - asm_state_e {FILL, HOLD, DRAIN}.
- The pooling stage imports the same constants.
- Single module; no sub-module is warranted. Buffer write is a per-slot enable decode of idx. idx width is $clog2(H*W), minimum 1.

Test Plan (H=W=2 unless stated):
- Nominal frame: 4 back-to-back beats, pixel p with all channel bytes = 8'h10+p, last on beat 3, map_ready=1. Expect:
  - map_valid high exactly 1 cycle after beat 3.
  - flat[255:0]=all 8'h10 … flat[1023:768]=all 8'h13.
  - frame_cnt=1; frame_err never high.
- Backpressure: hold map_ready=0 for 10 cycles with pix_valid=1 continuous. Expect:
  - pix_ready=0 and map output stable throughout.
  - After map_ready, pix_ready=1 one cycle later and the next frame assembles correctly.
- Short frame: last on beat 1. Expect:
  - frame_err pulse 1 cycle; no map_valid.
  - A following good 4-beat frame (bytes 8'hA0..A3) is presented intact; frame_cnt=1.
- Long frame: 6 beats, last on beat 5. Expect:
  - frame_err pulse after beat 3; beats 4–5 discarded; no map_valid.
  - Next good frame presented correctly.
- Reset mid-frame: assert rst_n=0 after 2 beats. Expect map_valid=0, pix_ready=0 during reset, frame_cnt=0. After release, a full good frame is delivered.
- H=W=1: beat 8'h7F×32 with last → map_valid next cycle, flat=all 8'h7F. Beat without last → frame_err, DRAIN until last.
